// File: rtl/tape_ear_conditioner.sv
// Tape EAR conditioner: turns the raw 12-bit tape ADC stream into a clean
// 1-bit EAR level. It tracks the DC level, slices the signal with hysteresis
// around it, glitch-filters the sliced bit and flags tape activity.
module tape_ear_conditioner #(
    parameter int unsigned SHIFT          = 6,
    parameter logic [11:0] HYST           = 12'd64,
    parameter int unsigned GLITCH_SAMPLES = 3,
    parameter int unsigned ACT_TIMEOUT    = 28000000
) (
    input  logic        clk_sys_i,
    input  logic        reset_n_i,
    input  logic [11:0] adc_sample_i,
    input  logic        adc_valid_i,
    input  logic        enable_i,
    output logic        ear_o,
    output logic        edge_o,
    output logic        active_o,
    output logic [11:0] dc_level_o
);

    localparam int unsigned ACC_W       = 12 + SHIFT;
    localparam logic [3:0]  GLITCH_CNT  = 4'(GLITCH_SAMPLES);
    localparam logic [31:0] TIMEOUT     = 32'(ACT_TIMEOUT);
    localparam logic [ACC_W-1:0] ACC_RST = ACC_W'(2048) << SHIFT;

    // Upper threshold, clamped at full scale instead of wrapping.
    function automatic logic [11:0] sat_hi(input logic [11:0] dc);
        logic [12:0] sum;
        sum = {1'b0, dc} + {1'b0, HYST};
        return sum[12] ? 12'hFFF : sum[11:0];
    endfunction

    // Lower threshold, clamped at zero instead of wrapping.
    function automatic logic [11:0] sat_lo(input logic [11:0] dc);
        logic [12:0] diff;
        diff = {1'b0, dc} - {1'b0, HYST};
        return diff[12] ? 12'h000 : diff[11:0];
    endfunction

    logic [ACC_W-1:0]        acc_q, acc_d;
    logic                    raw_q, raw_d;
    logic                    ear_q, ear_d;
    logic                    edge_q, edge_d;
    logic [3:0]              gcnt_q, gcnt_d;
    logic [31:0]             tcnt_q, tcnt_d;

    logic [11:0]             dc_level;
    logic [11:0]             th_hi, th_lo;
    logic signed [12:0]      err;
    logic signed [ACC_W:0]   acc_sum;
    logic [3:0]              gcnt_inc;

    assign dc_level = acc_q[ACC_W-1:SHIFT];
    assign th_hi    = sat_hi(dc_level);
    assign th_lo    = sat_lo(dc_level);
    assign gcnt_inc = gcnt_q + 4'd1;

    // Write acc = dc*2^SHIFT + f with 0 <= f < 2^SHIFT. After an update
    // acc' = dc*(2^SHIFT-1) + f + sample, which lies in
    // [0, 4095*(2^SHIFT-1) + (2^SHIFT-1) + 4095] = [0, 2^(12+SHIFT)-1],
    // so the ACC_W-bit accumulator can never wrap in either direction.
    assign err     = $signed({1'b0, adc_sample_i}) - $signed({1'b0, dc_level});
    assign acc_sum = $signed({1'b0, acc_q}) + (ACC_W+1)'(err);

    // Per-sample datapath: DC tracker, hysteresis slicer and glitch filter.
    always_comb begin
        acc_d  = acc_q;
        raw_d  = raw_q;
        gcnt_d = gcnt_q;
        ear_d  = ear_q;
        edge_d = 1'b0;
        if (adc_valid_i) begin
            acc_d = acc_sum[ACC_W-1:0];
            // Thresholds come from the pre-update DC level; equality holds.
            if (adc_sample_i > th_hi) begin
                raw_d = 1'b1;
            end else if (adc_sample_i < th_lo) begin
                raw_d = 1'b0;
            end
            if (raw_d == ear_q) begin
                gcnt_d = 4'd0;
            end else if (gcnt_inc == GLITCH_CNT) begin
                ear_d  = ~ear_q;
                gcnt_d = 4'd0;
                edge_d = 1'b1;
            end else begin
                gcnt_d = gcnt_inc;
            end
        end
    end

    // Activity timer: an edge reloads it, otherwise it runs down to zero.
    always_comb begin
        if (edge_d) begin
            tcnt_d = TIMEOUT;
        end else if (tcnt_q != 32'd0) begin
            tcnt_d = tcnt_q - 32'd1;
        end else begin
            tcnt_d = tcnt_q;
        end
    end

    // State registers; asynchronous reset discards everything immediately.
    always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            acc_q  <= ACC_RST;
            raw_q  <= 1'b0;
            ear_q  <= 1'b0;
            edge_q <= 1'b0;
            gcnt_q <= 4'd0;
            tcnt_q <= 32'd0;
        end else begin
            acc_q  <= acc_d;
            raw_q  <= raw_d;
            ear_q  <= ear_d;
            edge_q <= edge_d;
            gcnt_q <= gcnt_d;
            tcnt_q <= tcnt_d;
        end
    end

    // Enable only masks the outputs; the filter and timer keep running.
    assign ear_o      = ear_q & enable_i;
    assign edge_o     = edge_q & enable_i;
    assign active_o   = (tcnt_q != 32'd0) & enable_i;
    assign dc_level_o = dc_level;

endmodule

// File: tb/tb_tape_ear_conditioner.sv
// Directed bench for tape_ear_conditioner: reset, square wave, glitch
// rejection, hysteresis edges, enable gating, timeout, mid-stream reset,
// DC drift and saturation at both rails.
module tb_tape_ear_conditioner;

    localparam int SHIFT = 6;
    localparam int HYST  = 64;
    localparam int TMO   = 1000;

    logic        clk_sys;
    logic        reset_n;
    logic [11:0] adc_sample;
    logic        adc_valid;
    logic        enable;
    logic        ear_o;
    logic        edge_o;
    logic        active_o;
    logic [11:0] dc_level_o;

    int n_checks = 0;
    int n_pass   = 0;
    int n_edges  = 0;
    int m_acc    = 2048 << SHIFT;

    tape_ear_conditioner #(
        .SHIFT         (SHIFT),
        .HYST          (12'(HYST)),
        .GLITCH_SAMPLES(3),
        .ACT_TIMEOUT   (TMO)
    ) dut (
        .clk_sys_i   (clk_sys),
        .reset_n_i   (reset_n),
        .adc_sample_i(adc_sample),
        .adc_valid_i (adc_valid),
        .enable_i    (enable),
        .ear_o       (ear_o),
        .edge_o      (edge_o),
        .active_o    (active_o),
        .dc_level_o  (dc_level_o)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int m_dc();
        return m_acc >>> SHIFT;
    endfunction

    function automatic int m_hi();
        int h;
        h = m_dc() + HYST;
        return (h > 4095) ? 4095 : h;
    endfunction

    function automatic int m_lo();
        int l;
        l = m_dc() - HYST;
        return (l < 0) ? 0 : l;
    endfunction

    // One clock: drive at the falling edge, look 1 time unit after the rise.
    task automatic step(input logic v, input int s);
        @(negedge clk_sys);
        adc_valid  = v;
        adc_sample = 12'(s);
        @(posedge clk_sys);
        #1;
        adc_valid = 1'b0;
        if (v) m_acc = m_acc + s - (m_acc >>> SHIFT);
        if (edge_o) n_edges++;
    endtask

    initial begin
        reset_n    = 1'b0;
        adc_valid  = 1'b0;
        adc_sample = 12'd0;
        enable     = 1'b1;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b1;
        #1;
        check_val("rst_ear", ear_o, 0);
        check_val("rst_edge", edge_o, 0);
        check_val("rst_active", active_o, 0);
        check_val("rst_dc", dc_level_o, 2048);

        // Quiet input at the reset DC level changes nothing.
        repeat (1000) step(1, 2048);
        check_val("quiet_ear", ear_o, 0);
        check_val("quiet_active", active_o, 0);
        check_val("quiet_dc", dc_level_o, 2048);
        check_val("quiet_edges", n_edges, 0);

        // Square wave 2048 +/- 400, 16 samples per half.
        for (int h = 0; h < 8; h++) begin
            int   v;
            logic nw;
            nw = (h % 2 == 0);
            v  = nw ? 2448 : 1648;
            for (int k = 0; k < 16; k++) begin
                step(1, v);
                if (k == 1) check_val("sq_hold", ear_o, int'(!nw));
                if (k == 2) begin
                    check_val("sq_flip", ear_o, int'(nw));
                    check_val("sq_edge", edge_o, 1);
                    check_val("sq_active", active_o, 1);
                end
                if (k == 3) check_val("sq_edge_clr", edge_o, 0);
            end
        end
        check_val("sq_edges", n_edges, 8);
        check_val("sq_dc", dc_level_o, m_dc());

        // Glitch rejection: two opposing samples never flip ear.
        repeat (8) step(1, 2448);
        check_val("gl_ear_up", ear_o, 1);
        n_edges = 0;
        repeat (2) step(1, 1648);
        check_val("gl_ear_hold1", ear_o, 1);
        step(1, 2448);
        repeat (2) step(1, 1648);
        check_val("gl_ear_hold2", ear_o, 1);
        step(1, 2448);
        check_val("gl_edges", n_edges, 0);

        // Hysteresis with ear=1: samples exactly on the thresholds hold.
        for (int i = 0; i < 10; i++) begin
            step(1, m_hi());
            step(1, m_lo());
        end
        check_val("hy1_ear", ear_o, 1);
        check_val("hy1_edges", n_edges, 0);
        check_val("hy1_dc", dc_level_o, m_dc());
        step(1, m_hi() + 1);
        step(1, m_lo() - 1);
        step(1, m_lo() - 1);
        check_val("hy_fall_hold", ear_o, 1);
        step(1, m_lo() - 1);
        check_val("hy_fall_ear", ear_o, 0);
        check_val("hy_fall_edge", edge_o, 1);
        check_val("hy_fall_count", n_edges, 1);
        // Hysteresis with ear=0.
        for (int i = 0; i < 10; i++) begin
            step(1, m_lo());
            step(1, m_hi());
        end
        check_val("hy0_ear", ear_o, 0);
        check_val("hy0_edges", n_edges, 1);

        // Enable gating and filter running underneath.
        repeat (3) step(1, m_dc() + 300);
        check_val("en_ear", ear_o, 1);
        check_val("en_edge", edge_o, 1);
        enable = 1'b0;
        #1;
        check_val("dis_ear", ear_o, 0);
        check_val("dis_edge", edge_o, 0);
        check_val("dis_active", active_o, 0);
        enable = 1'b1;
        #1;
        check_val("reen_ear", ear_o, 1);
        check_val("reen_edge", edge_o, 1);
        check_val("reen_active", active_o, 1);
        enable = 1'b0;
        repeat (3) step(1, m_dc() - 300);
        check_val("dis_run_ear", ear_o, 0);
        check_val("dis_run_edge", edge_o, 0);
        enable = 1'b1;
        #1;
        check_val("reen_run_ear", ear_o, 0);
        check_val("reen_run_edge", edge_o, 1);
        check_val("reen_run_active", active_o, 1);

        // Activity timeout: drops exactly TMO clocks after the last edge.
        step(0, 0);
        check_val("to_edge_clr", edge_o, 0);
        repeat (TMO - 2) step(0, 0);
        check_val("to_still_active", active_o, 1);
        step(0, 0);
        check_val("to_dropped", active_o, 0);

        // Asynchronous reset in the middle of a cycle.
        repeat (3) step(1, m_dc() + 300);
        check_val("mr_ear_before", ear_o, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("mr_ear", ear_o, 0);
        check_val("mr_active", active_o, 0);
        check_val("mr_dc", dc_level_o, 2048);
        @(negedge clk_sys);
        reset_n = 1'b1;
        m_acc   = 2048 << SHIFT;
        step(1, 2448);
        check_val("mr_first_dc", dc_level_o, 2054);
        step(1, 1648);
        check_val("mr_second_dc", dc_level_o, m_dc());
        check_val("mr_second_ear", ear_o, 0);

        // DC drift: ramp 2048 -> 3000 over 20000 samples, +/-400 on top.
        reset_n = 1'b0;
        #1;
        @(negedge clk_sys);
        reset_n = 1'b1;
        m_acc   = 2048 << SHIFT;
        n_edges = 0;
        for (int i = 0; i < 20000; i++) begin
            int off;
            off = 2048 + (952 * i) / 20000;
            step(1, ((i / 16) % 2 == 0) ? off + 400 : off - 400);
        end
        check_val("dr_edges", n_edges, 1250);
        check_val("dr_dc_model", dc_level_o, m_dc());
        check_val("dr_dc_window", int'(dc_level_o >= 12'(3000 - HYST) &&
                                       dc_level_o <= 12'(3000 + HYST)), 1);

        // Saturation at full scale.
        repeat (2000) step(1, 4095);
        check_val("sat_hi_dc", dc_level_o, 4095);
        check_val("sat_hi_ear", ear_o, 1);
        repeat (100) step(1, 4095);
        check_val("sat_hi_nowrap", dc_level_o, 4095);
        step(1, m_lo() - 1);
        step(1, m_lo() - 1);
        check_val("sat_hi_hold", ear_o, 1);
        step(1, m_lo() - 1);
        check_val("sat_hi_fall", ear_o, 0);

        // Saturation at zero.
        repeat (2000) step(1, 0);
        check_val("sat_lo_dc", dc_level_o, 0);
        check_val("sat_lo_ear", ear_o, 0);
        step(1, m_hi() + 1);
        step(1, m_hi() + 1);
        check_val("sat_lo_hold", ear_o, 0);
        step(1, m_hi() + 1);
        check_val("sat_lo_rise", ear_o, 1);
        check_val("sat_lo_edge", edge_o, 1);
        check_val("sat_lo_dc_model", dc_level_o, m_dc());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
